// File: rtl/motion_pkg.sv
// ============================================================================
// Module : motion_pkg
// Brief  : Shared state encoding and default frame geometry for the motion
//          frame accumulator.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package motion_pkg;

  typedef enum logic [0:0] {WAIT_SOF, ACCUM} acc_state_t;

  localparam int FRAME_WIDTH             = 320;
  localparam int FRAME_HEIGHT            = 240;
  localparam int DEFAULT_FRAME_PIXELS    = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int DEFAULT_PIXEL_THRESHOLD = 500;

endpackage

`default_nettype wire

// File: rtl/motion_frame_accumulator.sv
// ============================================================================
// Module : motion_frame_accumulator
// Brief  : Counts motion pixels per frame, publishes a thresholded verdict over
//          a valid/ack handshake and flags short frames and lost sof.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module motion_frame_accumulator
  import motion_pkg::*;
#(
  parameter int FRAME_PIXELS    = DEFAULT_FRAME_PIXELS,
  parameter int PIXEL_THRESHOLD = DEFAULT_PIXEL_THRESHOLD,
  localparam int CNT_W          = $clog2(FRAME_PIXELS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_data,
  input  logic             frame_difference,
  input  logic             sof,
  input  logic             result_ack,
  output logic             result_valid,
  output logic             motion_detected,
  output logic [CNT_W-1:0] motion_count,
  output logic             frame_overrun,
  output logic             short_frame,
  output logic             sync_err
);

  acc_state_t       state, state_nxt;
  logic [CNT_W-1:0] pix_cnt, pix_nxt, pix_inc;
  logic [CNT_W-1:0] mot_cnt, mot_nxt, mot_inc;
  logic             done, short_nxt, sync_nxt;

  always_comb begin
    state_nxt = state;
    pix_nxt   = pix_cnt;
    mot_nxt   = mot_cnt;
    done      = 1'b0;
    short_nxt = 1'b0;
    sync_nxt  = 1'b0;
    pix_inc   = pix_cnt + 1'b1;
    mot_inc   = mot_cnt + CNT_W'(frame_difference);

    if (valid_data) begin
      if (state == WAIT_SOF || pix_cnt == '0) begin
        // Frame boundary: only an sof pixel may open a frame.
        if (sof) begin
          state_nxt = ACCUM;
          pix_nxt   = CNT_W'(1);
          mot_nxt   = CNT_W'(frame_difference);
        end else if (state == ACCUM) begin
          sync_nxt  = 1'b1;
          state_nxt = WAIT_SOF;
        end
      end else if (sof) begin
        short_nxt = 1'b1;
        pix_nxt   = CNT_W'(1);
        mot_nxt   = CNT_W'(frame_difference);
      end else if (pix_inc == CNT_W'(FRAME_PIXELS)) begin
        done    = 1'b1;
        pix_nxt = '0;
        mot_nxt = '0;
      end else begin
        pix_nxt = pix_inc;
        mot_nxt = mot_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= WAIT_SOF;
      pix_cnt         <= '0;
      mot_cnt         <= '0;
      result_valid    <= 1'b0;
      motion_detected <= 1'b0;
      motion_count    <= '0;
      frame_overrun   <= 1'b0;
      short_frame     <= 1'b0;
      sync_err        <= 1'b0;
    end else begin
      state         <= state_nxt;
      pix_cnt       <= pix_nxt;
      mot_cnt       <= mot_nxt;
      short_frame   <= short_nxt;
      sync_err      <= sync_nxt;
      frame_overrun <= done && result_valid && !result_ack;
      if (done) begin
        // mot_inc already includes the completing pixel.
        result_valid    <= 1'b1;
        motion_count    <= mot_inc;
        motion_detected <= 32'(mot_inc) >= 32'(PIXEL_THRESHOLD);
      end else if (result_ack) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_motion_frame_accumulator.sv
// ============================================================================
// Module : tb_motion_frame_accumulator
// Brief  : Randomized and directed checks against a frame-level reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_motion_frame_accumulator;

  localparam int FP    = 16;
  localparam int THR   = 4;
  localparam int CW    = $clog2(FP + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          valid_data = 1'b0;
  logic          frame_difference = 1'b0;
  logic          sof = 1'b0;
  logic          result_ack = 1'b0;
  logic          result_valid, motion_detected, frame_overrun, short_frame, sync_err;
  logic [CW-1:0] motion_count;

  motion_frame_accumulator #(.FRAME_PIXELS(FP), .PIXEL_THRESHOLD(THR)) dut (
    .clk              (clk),
    .reset            (reset),
    .valid_data       (valid_data),
    .frame_difference (frame_difference),
    .sof              (sof),
    .result_ack       (result_ack),
    .result_valid     (result_valid),
    .motion_detected  (motion_detected),
    .motion_count     (motion_count),
    .frame_overrun    (frame_overrun),
    .short_frame      (short_frame),
    .sync_err         (sync_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the current frame is a list of motion bits.
  bit in_sync;
  int frame_bits[$];
  bit m_rv, m_det, m_ovr, m_short, m_sync;
  int m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"},   32'(result_valid),    32'(m_rv));
    check({tag, ".count"},   32'(motion_count),    32'(m_cnt));
    check({tag, ".det"},     32'(motion_detected), 32'(m_det));
    check({tag, ".overrun"}, 32'(frame_overrun),   32'(m_ovr));
    check({tag, ".short"},   32'(short_frame),     32'(m_short));
    check({tag, ".sync"},    32'(sync_err),        32'(m_sync));
  endtask

  task automatic model_clear();
    in_sync = 0;
    frame_bits.delete();
    m_rv = 0; m_det = 0; m_ovr = 0; m_short = 0; m_sync = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit v, input bit fd, input bit s, input bit ack);
    bit complete = 0;
    int total = 0;
    m_ovr = 0; m_short = 0; m_sync = 0;
    if (v) begin
      if (!in_sync) begin
        if (s) begin in_sync = 1; frame_bits = '{int'(fd)}; end
      end else if (frame_bits.size() == 0) begin
        if (s) frame_bits.push_back(int'(fd));
        else begin m_sync = 1; in_sync = 0; end
      end else if (s) begin
        m_short = 1;
        frame_bits = '{int'(fd)};
      end else begin
        frame_bits.push_back(int'(fd));
        if (frame_bits.size() == FP) begin
          complete = 1;
          foreach (frame_bits[i]) total += frame_bits[i];
          frame_bits.delete();
        end
      end
    end
    if (complete) begin
      m_ovr = m_rv && !ack;
      m_rv  = 1;
      m_cnt = total;
      m_det = (total >= THR);
    end else if (ack) begin
      m_rv = 0;
    end
  endtask

  task automatic cycle(input string tag, input bit v, input bit fd, input bit s, input bit ack);
    valid_data = v; frame_difference = fd; sof = s; result_ack = ack;
    @(posedge clk);
    model_step(v, fd, s, ack);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n, input bit ack);
    for (int i = 0; i < n; i++) cycle(tag, 0, 0, 0, ack);
  endtask

  // Sends n pixels (first one with sof if requested), optionally with random gaps;
  // ack is raised only alongside the final pixel when ack_last is set.
  task automatic send_pixels(input string tag, input int n, input bit first_sof,
                             input logic [15:0] mask, input bit gaps, input bit ack_last);
    for (int p = 0; p < n; p++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) cycle(tag, 0, $urandom_range(0, 1), 0, 0);
      end
      cycle(tag, 1, mask[p % 16], (p == 0) && first_sof, ack_last && (p == n - 1));
    end
  endtask

  task automatic do_reset(input string tag);
    #2;
    reset = 0;
    valid_data = 0; sof = 0; result_ack = 0; frame_difference = 0;
    model_clear();
    #1;
    check_all(tag);
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    model_clear();
    #12;
    check_all("reset");
    @(negedge clk);
    reset = 1;

    // Basic frame, 5 motion bits, held until ack.
    send_pixels("frame5", FP, 1, 16'b1000_0100_0010_0011, 0, 0);
    idle("hold", 4, 0);
    idle("ack", 1, 1);
    idle("after_ack", 2, 1);

    // 3 motion bits with gaps.
    send_pixels("frame3_gaps", FP, 1, 16'h0421, 1, 0);
    idle("hold3", 2, 0);

    // Back-to-back without ack -> overrun, then with coincident ack -> none.
    send_pixels("b2b_a", FP, 1, 16'hFFFF, 0, 0);
    send_pixels("b2b_ack", FP, 1, 16'h00F0, 0, 1);
    idle("b2b_ack_hold", 2, 0);
    idle("b2b_clear", 1, 1);

    // Short frame: restart at pixel 9.
    send_pixels("short_head", 9, 1, 16'hFFFF, 0, 0);
    send_pixels("short_restart", FP, 1, 16'h1111, 0, 0);
    idle("short_ack", 1, 1);

    // Pixels without sof after reset are ignored, then a lost sof.
    do_reset("reset2");
    send_pixels("nosof", 5, 0, 16'hFFFF, 0, 0);
    send_pixels("after_nosof", FP, 1, 16'h0F0F, 1, 0);
    send_pixels("sync_lost", 1, 0, 16'h0001, 0, 0);
    send_pixels("resync", FP, 1, 16'h8001, 0, 1);

    // Reset mid-frame with a pending result.
    send_pixels("pending", FP, 1, 16'hAAAA, 0, 0);
    send_pixels("partial", 7, 1, 16'hFFFF, 0, 0);
    do_reset("reset_mid");
    send_pixels("post_reset", FP, 1, 16'h0007, 0, 0);
    idle("post_reset_ack", 1, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 1),
            $urandom_range(0, 29) == 0, $urandom_range(0, 5) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
